hazard_unit: RTL and testbench

Decode-stage hazard detector that drives `hazard_detected` into the controller and the IF/ID freeze logic. Keeps a two-entry shadow of the destination registers in flight in EXE and MEM, compares them against the source registers of the instruction in ID, and raises a stall when a read-after-write dependency cannot be covered. Also inserts bubbles on a taken-branch flush and keeps a saturating stall counter for performance analysis.

---
 rtl/hazard_unit_pkg.sv | 28 ++
 rtl/hazard_unit_stage_shadow.sv | 78 +++++++
 rtl/hazard_unit.sv | 116 +++++++++++
 tb/tb_hazard_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared constants and helpers for the decode-stage hazard detector.
// Latency: n/a (package only, no logic state).
// Backpressure: n/a; the stall it produces is the pipeline's backpressure.
package hazard_unit_pkg;

    // Register-address and opcode widths used across the core's decode path.
    localparam int REG_ADDR_LEN_DFLT = 5;
    localparam int OP_CODE_LEN       = 4;

    // Default width of the performance stall counter.
    localparam int CNT_LEN_DFLT      = 16;

    // Register 0 is hard-wired to zero, so it can never carry a dependency.
    localparam int ZERO_REG          = 0;

    // A shadow entry produces a RAW match against a source only when the
    // entry holds a real instruction that writes back, the addresses agree
    // and the source is not the zero register.
    function automatic logic entry_match(
        input logic entry_v,
        input logic entry_wb,
        input logic addr_eq,
        input logic src_nonzero
    );
        return entry_v & entry_wb & addr_eq & src_nonzero;
    endfunction

endpackage : hazard_unit_pkg

// File: rtl/hazard_unit_stage_shadow.sv
// Two-entry shadow of the destination registers in flight in EXE and MEM.
// Latency: 1 cycle per stage; MEM always takes last cycle's EXE entry.
// Backpressure: none; a bubble input replaces the incoming EXE entry.
module stage_shadow
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_LEN = REG_ADDR_LEN_DFLT
) (
    input  logic                    clk,
    input  logic                    rst,
    // Candidate entry for EXE: the instruction currently in ID.
    input  logic                    i_in_v,
    input  logic [REG_ADDR_LEN-1:0] i_in_dest,
    input  logic                    i_in_wb,
    input  logic                    i_in_ld,
    // Replace the candidate with a bubble (stall or flush).
    input  logic                    i_bubble,
    // EXE entry.
    output logic                    o_exe_v,
    output logic [REG_ADDR_LEN-1:0] o_exe_dest,
    output logic                    o_exe_wb,
    output logic                    o_exe_ld,
    // MEM entry; the load flag is dropped because forwarding covers MEM.
    output logic                    o_mem_v,
    output logic [REG_ADDR_LEN-1:0] o_mem_dest,
    output logic                    o_mem_wb
);

    logic                    r_exe_v;
    logic [REG_ADDR_LEN-1:0] r_exe_dest;
    logic                    r_exe_wb;
    logic                    r_exe_ld;
    logic                    r_mem_v;
    logic [REG_ADDR_LEN-1:0] r_mem_dest;
    logic                    r_mem_wb;

    // EXE stage: accept the ID instruction, or a bubble when it is held/squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe_v    <= 1'b0;
            r_exe_dest <= '0;
            r_exe_wb   <= 1'b0;
            r_exe_ld   <= 1'b0;
        end else if (i_bubble) begin
            r_exe_v    <= 1'b0;
            r_exe_dest <= '0;
            r_exe_wb   <= 1'b0;
            r_exe_ld   <= 1'b0;
        end else begin
            r_exe_v    <= i_in_v;
            r_exe_dest <= i_in_dest;
            r_exe_wb   <= i_in_wb;
            r_exe_ld   <= i_in_ld;
        end
    end

    // MEM stage: EXE never stalls, so MEM unconditionally follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_v    <= 1'b0;
            r_mem_dest <= '0;
            r_mem_wb   <= 1'b0;
        end else begin
            r_mem_v    <= r_exe_v;
            r_mem_dest <= r_exe_dest;
            r_mem_wb   <= r_exe_wb;
        end
    end

    assign o_exe_v    = r_exe_v;
    assign o_exe_dest = r_exe_dest;
    assign o_exe_wb   = r_exe_wb;
    assign o_exe_ld   = r_exe_ld;
    assign o_mem_v    = r_mem_v;
    assign o_mem_dest = r_mem_dest;
    assign o_mem_wb   = r_mem_wb;

endmodule : stage_shadow

// File: rtl/hazard_unit.sv
// Decode-stage RAW hazard detector with flush bubbles and a stall counter.
// Latency: hazard_detected is combinational from the ID inputs and shadow.
// Backpressure: hazard_detected is the stall request to controller and IF/ID.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter bit FORWARD_EN   = 1'b1,
    parameter int REG_ADDR_LEN = REG_ADDR_LEN_DFLT,
    parameter int CNT_LEN      = CNT_LEN_DFLT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] src1,
    input  logic [REG_ADDR_LEN-1:0] src2,
    input  logic                    src2_used,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic                    id_wb_en,
    input  logic                    id_mem_r_en,
    input  logic                    flush,
    output logic                    hazard_detected,
    output logic [CNT_LEN-1:0]      stall_count
);

    localparam logic [REG_ADDR_LEN-1:0] ZERO_ADDR = REG_ADDR_LEN'(ZERO_REG);
    localparam logic [CNT_LEN-1:0]      CNT_ONE   = {{(CNT_LEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_LEN-1:0]      CNT_MAX   = {CNT_LEN{1'b1}};

    // Shadow outputs.
    logic                    w_exe_v;
    logic [REG_ADDR_LEN-1:0] w_exe_dest;
    logic                    w_exe_wb;
    logic                    w_exe_ld;
    logic                    w_mem_v;
    logic [REG_ADDR_LEN-1:0] w_mem_dest;
    logic                    w_mem_wb;

    // Source liveness and per-entry matches.
    logic w_live1;
    logic w_live2;
    logic w_exe_hit1;
    logic w_exe_hit2;
    logic w_mem_hit1;
    logic w_mem_hit2;
    logic w_exe_hit;
    logic w_mem_hit;
    logic w_raw;
    logic w_hazard;
    logic w_bubble;

    logic [CNT_LEN-1:0] r_stall_count;

    assign w_live1 = id_valid;
    assign w_live2 = id_valid & src2_used;

    assign w_exe_hit1 = w_live1 & entry_match(w_exe_v, w_exe_wb,
                                              (w_exe_dest == src1), (src1 != ZERO_ADDR));
    assign w_exe_hit2 = w_live2 & entry_match(w_exe_v, w_exe_wb,
                                              (w_exe_dest == src2), (src2 != ZERO_ADDR));
    assign w_mem_hit1 = w_live1 & entry_match(w_mem_v, w_mem_wb,
                                              (w_mem_dest == src1), (src1 != ZERO_ADDR));
    assign w_mem_hit2 = w_live2 & entry_match(w_mem_v, w_mem_wb,
                                              (w_mem_dest == src2), (src2 != ZERO_ADDR));

    // Both sources hitting the same entry collapse into one stall request.
    assign w_exe_hit = w_exe_hit1 | w_exe_hit2;
    assign w_mem_hit = w_mem_hit1 | w_mem_hit2;

    // With forwarding only a load in EXE cannot be covered (data arrives
    // after MEM); without it any producer still in EXE or MEM blocks ID.
    generate
        if (FORWARD_EN) begin : g_fwd
            assign w_raw = w_exe_hit & w_exe_ld;
        end else begin : g_nofwd
            assign w_raw = w_exe_hit | w_mem_hit;
        end
    endgenerate

    // A flushed ID instruction is dead, so it can never request a stall.
    assign w_hazard = w_raw & ~flush;

    // Stalled or squashed instructions leave a bubble behind in EXE.
    assign w_bubble = w_hazard | flush;

    stage_shadow #(
        .REG_ADDR_LEN (REG_ADDR_LEN)
    ) u_stage_shadow (
        .clk        (clk),
        .rst        (rst),
        .i_in_v     (id_valid),
        .i_in_dest  (id_dest),
        .i_in_wb    (id_wb_en),
        .i_in_ld    (id_mem_r_en),
        .i_bubble   (w_bubble),
        .o_exe_v    (w_exe_v),
        .o_exe_dest (w_exe_dest),
        .o_exe_wb   (w_exe_wb),
        .o_exe_ld   (w_exe_ld),
        .o_mem_v    (w_mem_v),
        .o_mem_dest (w_mem_dest),
        .o_mem_wb   (w_mem_wb)
    );

    // Stall counter: one per stalled cycle, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_hazard && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_ONE;
        end
    end

    assign hazard_detected = w_hazard;
    assign stall_count     = r_stall_count;

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding and non-forwarding instances.
// Latency: checks combinational hazard at negedge, counters after edges.
// Backpressure: bench re-presents a stalled instruction, as IF/ID would.
module tb_hazard_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       src2_used;
    logic [4:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic       flush;

    logic        hz_a;
    logic [15:0] cnt_a;
    logic        hz_b;
    logic [3:0]  cnt_b;

    int n_chk;
    int n_fail;

    // Instance A: forwarding present, 16-bit counter.
    hazard_unit #(
        .FORWARD_EN   (1'b1),
        .REG_ADDR_LEN (5),
        .CNT_LEN      (16)
    ) u_dut_fwd (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .src1            (src1),
        .src2            (src2),
        .src2_used       (src2_used),
        .id_dest         (id_dest),
        .id_wb_en        (id_wb_en),
        .id_mem_r_en     (id_mem_r_en),
        .flush           (flush),
        .hazard_detected (hz_a),
        .stall_count     (cnt_a)
    );

    // Instance B: no forwarding, 4-bit counter to reach saturation quickly.
    hazard_unit #(
        .FORWARD_EN   (1'b0),
        .REG_ADDR_LEN (5),
        .CNT_LEN      (4)
    ) u_dut_nofwd (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .src1            (src1),
        .src2            (src2),
        .src2_used       (src2_used),
        .id_dest         (id_dest),
        .id_wb_en        (id_wb_en),
        .id_mem_r_en     (id_mem_r_en),
        .flush           (flush),
        .hazard_detected (hz_b),
        .stall_count     (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present an ID instruction, then move to the negedge where outputs are stable.
    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic s2u, input logic [4:0] d, input logic wb,
                         input logic ld, input logic fl);
        id_valid    = v;
        src1        = s1;
        src2        = s2;
        src2_used   = s2u;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        flush       = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        id_valid = 1'b0; src1 = '0; src2 = '0; src2_used = 1'b0;
        id_dest = '0; id_wb_en = 1'b0; id_mem_r_en = 1'b0; flush = 1'b0;

        // Reset then idle: no hazard, counters at zero.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            check("idle_hz_a", 32'(hz_a), 0);
            check("idle_hz_b", 32'(hz_b), 0);
            tick();
        end
        check("idle_cnt_a", 32'(cnt_a), 0);
        check("idle_cnt_b", 32'(cnt_b), 0);

        // LD r3 then ADD r4,r3,r5: one stall with forwarding, two without.
        do_reset();
        drive(1, 5'd1, 5'd0, 0, 5'd3, 1, 1, 0);
        check("ld_hz_a", 32'(hz_a), 0);
        check("ld_hz_b", 32'(hz_b), 0);
        tick();
        drive(1, 5'd3, 5'd5, 1, 5'd4, 1, 0, 0);
        check("lu1_hz_a", 32'(hz_a), 1);
        check("lu1_hz_b", 32'(hz_b), 1);
        tick();
        drive(1, 5'd3, 5'd5, 1, 5'd4, 1, 0, 0);
        check("lu2_hz_a", 32'(hz_a), 0);
        check("lu2_hz_b", 32'(hz_b), 1);
        tick();
        drive(1, 5'd3, 5'd5, 1, 5'd4, 1, 0, 0);
        check("lu3_hz_a", 32'(hz_a), 0);
        check("lu3_hz_b", 32'(hz_b), 0);
        tick();
        idle();
        check("lu_cnt_a", 32'(cnt_a), 1);
        check("lu_cnt_b", 32'(cnt_b), 2);

        // ADD r3 then SUB r6,r3,r1 adjacent: two stalls without forwarding.
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        tick();
        drive(1, 5'd3, 5'd1, 1, 5'd6, 1, 0, 0);
        check("adj1_hz_a", 32'(hz_a), 0);
        check("adj1_hz_b", 32'(hz_b), 1);
        tick();
        drive(1, 5'd3, 5'd1, 1, 5'd6, 1, 0, 0);
        check("adj2_hz_b", 32'(hz_b), 1);
        tick();
        drive(1, 5'd3, 5'd1, 1, 5'd6, 1, 0, 0);
        check("adj3_hz_b", 32'(hz_b), 0);
        tick();
        idle();
        check("adj_cnt_a", 32'(cnt_a), 0);
        check("adj_cnt_b", 32'(cnt_b), 2);

        // Same pair with a NOP between: one stall.
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        tick();
        idle();
        check("nop_hz_b", 32'(hz_b), 0);
        tick();
        drive(1, 5'd3, 5'd1, 1, 5'd6, 1, 0, 0);
        check("gap1_hz_b", 32'(hz_b), 1);
        tick();
        drive(1, 5'd3, 5'd1, 1, 5'd6, 1, 0, 0);
        check("gap2_hz_b", 32'(hz_b), 0);
        tick();
        idle();
        check("gap_cnt_b", 32'(cnt_b), 1);

        // Both sources on the same producer count once per cycle.
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        tick();
        drive(1, 5'd3, 5'd3, 1, 5'd5, 1, 0, 0);
        check("dual1_hz_b", 32'(hz_b), 1);
        tick();
        drive(1, 5'd3, 5'd3, 1, 5'd5, 1, 0, 0);
        check("dual2_hz_b", 32'(hz_b), 1);
        tick();
        idle();
        check("dual_cnt_b", 32'(cnt_b), 2);

        // r0 producer and non-writing producer never stall.
        do_reset();
        drive(1, 5'd1, 5'd0, 0, 5'd0, 1, 1, 0);
        tick();
        drive(1, 5'd0, 5'd0, 1, 5'd9, 1, 0, 0);
        check("r0_hz_a", 32'(hz_a), 0);
        check("r0_hz_b", 32'(hz_b), 0);
        tick();
        drive(1, 5'd2, 5'd7, 1, 5'd7, 0, 0, 0);
        tick();
        drive(1, 5'd7, 5'd0, 0, 5'd11, 1, 0, 0);
        check("nowb_hz_a", 32'(hz_a), 0);
        check("nowb_hz_b", 32'(hz_b), 0);
        tick();

        // Flush beats a hazard and leaves a bubble in EXE.
        do_reset();
        drive(1, 5'd1, 5'd0, 0, 5'd3, 1, 1, 0);
        tick();
        drive(1, 5'd3, 5'd4, 1, 5'd8, 1, 0, 1);
        check("flush_hz_a", 32'(hz_a), 0);
        check("flush_hz_b", 32'(hz_b), 0);
        tick();
        drive(1, 5'd8, 5'd0, 1, 5'd10, 1, 0, 0);
        check("squash_hz_a", 32'(hz_a), 0);
        check("squash_hz_b", 32'(hz_b), 0);
        tick();
        idle();
        check("flush_cnt_a", 32'(cnt_a), 0);
        check("flush_cnt_b", 32'(cnt_b), 0);

        // Self-dependent ADD r3,r3 re-presented: counter saturates, reset clears.
        do_reset();
        for (int i = 0; i < 29; i++) begin
            drive(1, 5'd3, 5'd0, 0, 5'd3, 1, 0, 0);
            tick();
        end
        drive(1, 5'd3, 5'd0, 0, 5'd3, 1, 0, 0);
        check("sat_hz_b", 32'(hz_b), 1);
        check("sat_cnt_b", 32'(cnt_b), 15);
        check("sat_cnt_a", 32'(cnt_a), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 5'd3, 5'd0, 0, 5'd3, 1, 0, 0);
        check("rst_hz_b", 32'(hz_b), 0);
        check("rst_cnt_b", 32'(cnt_b), 0);
        tick();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_hazard_unit
